// File: rtl/display_timings.sv
// display_timings: parametrised raster timing generator (coordinates, syncs, DE, strobes, frame counter).
// Every output is registered from the next-position decode, so decodes always align with SX/SY.
`default_nettype none

module display_timings #(
  parameter int CORDW = 10,
  parameter int H_RES = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_BP  = 48,
  parameter int V_RES = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_BP  = 33,
  parameter int H_POL = 0,
  parameter int V_POL = 0,
  parameter int FNW   = 8
) (
  input  logic             PCLK,
  input  logic             RST_PCLK,
  input  logic             EN,
  output logic [CORDW-1:0] SX,
  output logic [CORDW-1:0] SY,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             DE,
  output logic             LINE,
  output logic             FRAME,
  output logic [FNW-1:0]   FRAME_NUM
);

  localparam int H_TOTAL = H_RES + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SW + V_BP;

  generate
    if (H_TOTAL > (1 << CORDW) || V_TOTAL > (1 << CORDW)) begin : g_bad_total
      $error("display_timings: H_TOTAL/V_TOTAL do not fit in CORDW bits");
    end
    if (H_SW == 0 || V_SW == 0 || H_RES == 0 || V_RES == 0) begin : g_bad_zero
      $error("display_timings: H_SW, V_SW, H_RES and V_RES must be non-zero");
    end
  endgenerate

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SW - 1);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SW - 1);
  localparam logic             HS_ON  = 1'(H_POL);
  localparam logic             VS_ON  = 1'(V_POL);

  logic [CORDW-1:0] next_sx;
  logic [CORDW-1:0] next_sy;
  logic             next_line;
  logic             next_frame;

  always_comb begin
    next_sx = SX + 1'b1;
    next_sy = SY;
    if (SX == H_LAST) begin
      next_sx = '0;
      next_sy = (SY == V_LAST) ? '0 : SY + 1'b1;
    end
    next_line  = (next_sx == '0);
    next_frame = next_line && (next_sy == '0);
  end

  always_ff @(posedge PCLK or posedge RST_PCLK) begin
    if (RST_PCLK) begin
      SX        <= H_LAST;
      SY        <= V_LAST;
      HSYNC     <= ~HS_ON;
      VSYNC     <= ~VS_ON;
      DE        <= 1'b0;
      LINE      <= 1'b0;
      FRAME     <= 1'b0;
      FRAME_NUM <= '1;
    end else if (EN) begin
      SX    <= next_sx;
      SY    <= next_sy;
      HSYNC <= (next_sx >= HS_BEG && next_sx <= HS_END) ? HS_ON : ~HS_ON;
      VSYNC <= (next_sy >= VS_BEG && next_sy <= VS_END) ? VS_ON : ~VS_ON;
      DE    <= (next_sx < H_ACT) && (next_sy < V_ACT);
      LINE  <= next_line;
      FRAME <= next_frame;
      // Counter advances on the edge that lands on (0,0), so reset's all-ones becomes 0 there.
      if (next_frame) FRAME_NUM <= FRAME_NUM + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_timings.sv
// Self-checking bench for display_timings: small raster with scoreboard model, plus a 1280x720 polarity instance.
`default_nettype none

module tb_display_timings;

  // Small raster: H 8/2/3/2 = 15, V 4/1/2/1 = 8; HSYNC 10..12, VSYNC 5..6, active-low.
  localparam int HT = 15;
  localparam int VT = 8;

  logic       PCLK = 1'b0;
  logic       RST_PCLK = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] SX, SY, FRAME_NUM;
  logic       HSYNC, VSYNC, DE, LINE, FRAME;

  logic        p_rst = 1'b1;
  logic        p_en = 1'b1;
  logic [10:0] p_sx, p_sy;
  logic        p_hs, p_vs, p_de, p_line, p_frame;
  logic [7:0]  p_fn;

  always #5 PCLK = ~PCLK;

  display_timings #(
    .CORDW(4), .H_RES(8), .H_FP(2), .H_SW(3), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SW(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .FNW(4)
  ) dut (
    .PCLK(PCLK), .RST_PCLK(RST_PCLK), .EN(EN),
    .SX(SX), .SY(SY), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
    .LINE(LINE), .FRAME(FRAME), .FRAME_NUM(FRAME_NUM)
  );

  display_timings #(
    .CORDW(11), .H_RES(1280), .H_FP(110), .H_SW(40), .H_BP(220),
    .V_RES(720), .V_FP(5), .V_SW(5), .V_BP(20),
    .H_POL(1), .V_POL(1), .FNW(8)
  ) dut_p (
    .PCLK(PCLK), .RST_PCLK(p_rst), .EN(p_en),
    .SX(p_sx), .SY(p_sy), .HSYNC(p_hs), .VSYNC(p_vs), .DE(p_de),
    .LINE(p_line), .FRAME(p_frame), .FRAME_NUM(p_fn)
  );

  typedef struct packed {
    logic [3:0] sx;
    logic [3:0] sy;
    logic       hs;
    logic       vs;
    logic       de;
    logic       line;
    logic       frame;
    logic [3:0] fn;
  } obs_t;

  typedef struct {
    logic en;
    obs_t exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  int   m_sx, m_sy, m_fn;

  function automatic obs_t model_obs(int x, int y, int f);
    obs_t o;
    o.sx    = 4'(x);
    o.sy    = 4'(y);
    o.hs    = !(x >= 10 && x <= 12);
    o.vs    = !(y >= 5 && y <= 6);
    o.de    = (x < 8) && (y < 4);
    o.line  = (x == 0);
    o.frame = (x == 0) && (y == 0);
    o.fn    = 4'(f);
    return o;
  endfunction

  function automatic obs_t mk(int x, int y, logic hs, logic vs, logic de, logic ln, logic fr, int f);
    obs_t o;
    o.sx = 4'(x); o.sy = 4'(y); o.hs = hs; o.vs = vs; o.de = de;
    o.line = ln; o.frame = fr; o.fn = 4'(f);
    return o;
  endfunction

  function automatic obs_t act_obs();
    obs_t o;
    o.sx = SX; o.sy = SY; o.hs = HSYNC; o.vs = VSYNC; o.de = DE;
    o.line = LINE; o.frame = FRAME; o.fn = FRAME_NUM;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t a, input obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s @%0t: got sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b fn=%0d, want sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b fn=%0d",
               name, $time, a.sx, a.sy, a.hs, a.vs, a.de, a.line, a.frame, a.fn,
               e.sx, e.sy, e.hs, e.vs, e.de, e.line, e.frame, e.fn);
    end
  endtask

  task automatic cmp_int(input string name, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endtask

  task automatic model_adv();
    if (m_sx == HT - 1) begin
      m_sx = 0;
      m_sy = (m_sy == VT - 1) ? 0 : m_sy + 1;
    end else begin
      m_sx = m_sx + 1;
    end
    if (m_sx == 0 && m_sy == 0) m_fn = (m_fn + 1) % 16;
  endtask

  // Called 1 time unit after a rising edge; drives EN, predicts, then checks after the next edge.
  task automatic step(input logic en);
    EN = en;
    if (en) model_adv();
    exp_q.push_back(model_obs(m_sx, m_sy, m_fn));
    @(posedge PCLK); #1;
    check_obs("sb", act_obs(), exp_q.pop_front());
  endtask

  initial begin
    vec_t vecs[13];
    int cnt_fr, cnt_ln, cnt_hs, cnt_vs, cnt_de;
    int rise1, rise2, nrise;
    logic prev_line, wrap_seen;
    logic [3:0] prev_fn;
    int hs_cnt, hs_min, hs_max, vs_bad;

    vecs[0]  = '{1'b1, mk(0, 0, 1, 1, 1, 1, 1, 0)};
    vecs[1]  = '{1'b0, mk(0, 0, 1, 1, 1, 1, 1, 0)};
    vecs[2]  = '{1'b0, mk(0, 0, 1, 1, 1, 1, 1, 0)};
    vecs[3]  = '{1'b1, mk(1, 0, 1, 1, 1, 0, 0, 0)};
    vecs[4]  = '{1'b1, mk(2, 0, 1, 1, 1, 0, 0, 0)};
    vecs[5]  = '{1'b1, mk(3, 0, 1, 1, 1, 0, 0, 0)};
    vecs[6]  = '{1'b1, mk(4, 0, 1, 1, 1, 0, 0, 0)};
    vecs[7]  = '{1'b1, mk(5, 0, 1, 1, 1, 0, 0, 0)};
    vecs[8]  = '{1'b1, mk(6, 0, 1, 1, 1, 0, 0, 0)};
    vecs[9]  = '{1'b1, mk(7, 0, 1, 1, 1, 0, 0, 0)};
    vecs[10] = '{1'b1, mk(8, 0, 1, 1, 0, 0, 0, 0)};
    vecs[11] = '{1'b1, mk(9, 0, 1, 1, 0, 0, 0, 0)};
    vecs[12] = '{1'b1, mk(10, 0, 0, 1, 0, 0, 0, 0)};

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check_obs("reset", act_obs(), mk(14, 7, 1, 1, 0, 0, 0, 15));
    RST_PCLK = 1'b0;

    foreach (vecs[i]) begin
      EN = vecs[i].en;
      @(posedge PCLK); #1;
      check_obs($sformatf("vec%0d", i), act_obs(), vecs[i].exp);
    end
    m_sx = 10; m_sy = 0; m_fn = 0;

    // Run to mid-frame and assert reset between edges
    for (int k = 0; k < 200 && !(m_sx == 6 && m_sy == 3); k++) step(1'b1);
    cmp_int("reach_mid", m_sx * 100 + m_sy, 603);
    #2 RST_PCLK = 1'b1;
    #1 check_obs("async_rst", act_obs(), mk(14, 7, 1, 1, 0, 0, 0, 15));
    @(posedge PCLK); #1;
    check_obs("rst_hold", act_obs(), mk(14, 7, 1, 1, 0, 0, 0, 15));
    RST_PCLK = 1'b0;
    m_sx = 14; m_sy = 7; m_fn = 15;
    step(1'b1);
    check_obs("restart", act_obs(), mk(0, 0, 1, 1, 1, 1, 1, 0));

    // Stall on (0,0): FRAME held, then resume at SX=1
    repeat (5) step(1'b0);
    step(1'b1);
    check_obs("resume", act_obs(), mk(1, 0, 1, 1, 1, 0, 0, 0));

    // One full frame of strobes and sync widths
    cnt_fr = 0; cnt_ln = 0; cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
    for (int k = 0; k < HT * VT; k++) begin
      step(1'b1);
      cnt_fr += FRAME; cnt_ln += LINE; cnt_hs += !HSYNC; cnt_vs += !VSYNC; cnt_de += DE;
    end
    cmp_int("frame_cnt", cnt_fr, 1);
    cmp_int("line_cnt", cnt_ln, VT);
    cmp_int("hs_cnt", cnt_hs, 3 * VT);
    cmp_int("vs_cnt", cnt_vs, 2 * HT);
    cmp_int("de_cnt", cnt_de, 8 * 4);

    // Alternating EN doubles line period
    nrise = 0; rise1 = 0; rise2 = 0; prev_line = LINE;
    for (int k = 0; k < 200 && nrise < 2; k++) begin
      step(k[0] == 1'b0);
      if (LINE && !prev_line) begin
        if (nrise == 0) rise1 = k; else rise2 = k;
        nrise++;
      end
      prev_line = LINE;
    end
    cmp_int("alt_rises", nrise, 2);
    cmp_int("alt_period", rise2 - rise1, 2 * HT);

    // Random EN over enough frames to wrap the 4-bit frame counter
    wrap_seen = 1'b0; prev_fn = FRAME_NUM;
    for (int k = 0; k < 3200; k++) begin
      step($urandom_range(0, 3) != 0);
      if (prev_fn == 4'hF && FRAME_NUM == 4'h0) wrap_seen = 1'b1;
      prev_fn = FRAME_NUM;
    end
    cmp_int("fn_wrap", int'(wrap_seen), 1);
    EN = 1'b0;

    // 1280x720 active-high instance
    check_obs("dummy_guard", act_obs(), model_obs(m_sx, m_sy, m_fn));
    cmp_int("p_rst_sx", int'(p_sx), 1649);
    cmp_int("p_rst_sy", int'(p_sy), 749);
    cmp_int("p_rst_sync", int'({p_hs, p_vs}), 0);
    p_rst = 1'b0;
    hs_cnt = 0; hs_min = 9999; hs_max = -1; vs_bad = 0;
    for (int k = 0; k < 1650; k++) begin
      @(posedge PCLK); #1;
      if (p_hs) begin
        hs_cnt++;
        if (int'(p_sx) < hs_min) hs_min = int'(p_sx);
        if (int'(p_sx) > hs_max) hs_max = int'(p_sx);
      end
      if (p_vs) vs_bad++;
    end
    cmp_int("p_last_sx", int'(p_sx), 1649);
    cmp_int("p_hs_cnt", hs_cnt, 40);
    cmp_int("p_hs_min", hs_min, 1390);
    cmp_int("p_hs_max", hs_max, 1429);
    cmp_int("p_vs_line0", vs_bad, 0);
    @(posedge PCLK); #1;
    cmp_int("p_wrap_xy", int'(p_sx) * 1000 + int'(p_sy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_timings.md
Name: display_timings

Overview:
- Parametrised raster timing generator; the successor to the fixed 640x480p60 timing block.
- Driven by PCLK from the rPLL wrapper; reset from !plock.
- Produces pixel coordinates, HSYNC/VSYNC with selectable polarity, DE, line/frame start strobes and a frame counter for any CEA/VESA mode set by parameters.
- A clock-enable input lets the raster be paused without losing position.

Parameters:
- CORDW, 10: coordinate width in bits; must satisfy 2^CORDW > max(H_TOTAL, V_TOTAL)-1.
- H_RES, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SW, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_RES, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SW, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_POL, 0: HSYNC active level (0 = active-low).
- V_POL, 0: VSYNC active level (0 = active-low).
- FNW, 8: FRAME_NUM width in bits.

Ports:
- PCLK  in  1  pixel clock, rising-edge.
- RST_PCLK  in  1  asynchronous, active-high reset.
- EN  in  1  count enable; low freezes all state.
- SX  out  CORDW  horizontal position, 0..H_TOTAL-1.
- SY  out  CORDW  vertical position, 0..V_TOTAL-1.
- HSYNC  out  1  horizontal sync, level per H_POL.
- VSYNC  out  1  vertical sync, level per V_POL.
- DE  out  1  high when SX<H_RES and SY<V_RES.
- LINE  out  1  one-cycle strobe when SX==0.
- FRAME  out  1  one-cycle strobe when SX==0 and SY==0.
- FRAME_NUM  out  FNW  frame counter, wraps modulo 2^FNW.

Behaviour:
- Derived values: H_TOTAL = H_RES+H_FP+H_SW+H_BP (default 800); V_TOTAL = V_RES+V_FP+V_SW+V_BP (default 525).
- All outputs are registered, with no combinational path from EN. In every cycle, HSYNC, VSYNC, DE, LINE and FRAME are the decode of the SX/SY presented in that same cycle: zero relative skew, no pipeline offset.
- Reset (asserted asynchronously, any time):
  - SX=H_TOTAL-1, SY=V_TOTAL-1, DE=0, LINE=0, FRAME=0.
  - HSYNC=~H_POL, VSYNC=~V_POL (inactive levels).
  - FRAME_NUM = all ones.
  - Reset mid-line or mid-frame discards position with no partial-line completion.
- First enabled edge after reset release: SX=0, SY=0, DE=1, LINE=1, FRAME=1, FRAME_NUM=0.
- Per enabled edge:
  - if SX==H_TOTAL-1: SX<=0, and SY<=(SY==V_TOTAL-1) ? 0 : SY+1.
  - else SX<=SX+1, SY unchanged.
- FRAME_NUM increments (wrapping) on each edge that produces (0,0).
- EN low: SX, SY, FRAME_NUM and every decoded output hold their current values.
  - A strobe that is high stays high while paused; it still marks the same pixel.
  - EN toggling every cycle halves the raster rate exactly.
- Decodes:
  - HSYNC active when H_RES+H_FP <= SX <= H_RES+H_FP+H_SW-1; defaults 656..751.
  - VSYNC active when V_RES+V_FP <= SY <= V_RES+V_FP+V_SW-1; defaults 490..491.
  - VSYNC changes on the same cycle SY changes (at SX=0), not at hsync.
- Arithmetic: comparisons are unsigned at CORDW width. Parameter sums are evaluated at 32 bits at elaboration.
- Elaboration errors (generate-time error or simulation $fatal):
  - H_TOTAL or V_TOTAL exceeds 2^CORDW.
  - Any of H_SW, V_SW, H_RES or V_RES is zero.

Test Plan:
- Reset defaults, EN=1, release reset, run 800 cycles.
  - First cycle after release: SX=0, SY=0, FRAME=1, LINE=1, DE=1, FRAME_NUM=0.
  - HSYNC low exactly for SX 656..751 (96 cycles).
  - DE high for 640 cycles per line.
- Full frame, 420000 cycles.
  - VSYNC low for SY 490..491 (1600 cycles).
  - FRAME pulses exactly once every 420000 cycles; FRAME_NUM increments by 1 each time.
  - LINE pulses 525 times per frame.
- Wrap: observe the cycle SX=799, SY=524.
  - Next cycle is SX=0, SY=0, FRAME=1.
  - FRAME_NUM wraps 255->0 after 256 frames (simulate with reduced-size parameters, e.g. H_TOTAL=8, V_TOTAL=6).
- EN stall: deassert EN for 5 cycles at SX=0, SY=0.
  - All outputs frozen, including FRAME=1 held for all 5 cycles.
  - Resumes at SX=1 with FRAME=0.
  - EN alternating 1/0 yields 1600 cycles per line.
- Polarity: H_POL=1, V_POL=1 with a 1280x720 set (CORDW=11, H 1280/110/40/220, V 720/5/5/20).
  - HSYNC high for SX 1390..1429.
  - VSYNC high for SY 725..729.
  - H_TOTAL=1650, V_TOTAL=750.
- Async reset mid-frame: assert RST_PCLK at SX=300, SY=200, between clock edges.
  - Outputs take reset values immediately, without waiting for an edge.
  - After release, restarts at (0,0) with FRAME_NUM=0.
